// File: rtl/vp_pkg.sv
// Shared widths, FSM encoding and helpers for the centroid overlay pipeline.
// Coordinates are 11 bit; the pixel-count and moment accumulators are 20 and 32 bit.
package vp_pkg;

    localparam int COORD_W = 11;
    localparam int M00_W   = 20;
    localparam int MOM_W   = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DIV_X = 2'd1,
        ST_DIV_Y = 2'd2,
        ST_DONE  = 2'd3
    } cent_state_t;

    // Counter increment that sticks at max_v instead of wrapping
    function automatic logic [COORD_W-1:0] sat_inc(input logic [COORD_W-1:0] v,
                                                   input logic [COORD_W-1:0] max_v);
        return (v >= max_v) ? max_v : v + 1'b1;
    endfunction

endpackage

// File: rtl/seq_div.sv
// Restoring divider, one quotient bit per clock, MOM_W cycles per division.
// A new start aborts any division in flight; done pulses for one cycle.
module seq_div
    import vp_pkg::*;
#(
    parameter int QW = COORD_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [MOM_W-1:0] dividend,
    input  logic [MOM_W-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [QW-1:0]    quotient
);

    localparam int CNT_W = $clog2(MOM_W + 1);

    logic [MOM_W-1:0] rem_reg;
    logic [MOM_W-1:0] quo_reg;
    logic [MOM_W-1:0] dvs_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             busy_reg;
    logic             done_reg;
    logic [MOM_W:0]   rem_shift;
    logic [MOM_W:0]   diff;

    // Dividend bits shift out of the quotient register into the partial remainder
    assign rem_shift = {rem_reg, quo_reg[MOM_W-1]};
    assign diff      = rem_shift - {1'b0, dvs_reg};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_reg  <= '0;
            quo_reg  <= '0;
            dvs_reg  <= '0;
            cnt_reg  <= '0;
            busy_reg <= 1'b0;
            done_reg <= 1'b0;
        end else if (start) begin
            rem_reg  <= '0;
            quo_reg  <= dividend;
            dvs_reg  <= divisor;
            cnt_reg  <= CNT_W'(MOM_W);
            busy_reg <= 1'b1;
            done_reg <= 1'b0;
        end else if (busy_reg) begin
            quo_reg <= {quo_reg[MOM_W-2:0], ~diff[MOM_W]};
            rem_reg <= diff[MOM_W] ? rem_shift[MOM_W-1:0] : diff[MOM_W-1:0];
            cnt_reg <= cnt_reg - 1'b1;
            if (cnt_reg == CNT_W'(1)) begin
                busy_reg <= 1'b0;
                done_reg <= 1'b1;
            end
        end else begin
            done_reg <= 1'b0;
        end
    end

    assign busy     = busy_reg;
    assign done     = done_reg;
    assign quotient = quo_reg[QW-1:0];

endmodule

// File: rtl/centroid_overlay.sv
// Per-frame centroid of foreground pixels, computed after each v_sync rise and
// drawn as a cross (row y_c, column x_c) over the 1-cycle delayed video.
module centroid_overlay
    import vp_pkg::*;
#(
    parameter int          IMG_W      = 1280,
    parameter int          IMG_H      = 720,
    parameter logic [23:0] MARK_COLOR = 24'hFF0000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [23:0]        pixel_in,
    input  logic               de_in,
    input  logic               h_sync_in,
    input  logic               v_sync_in,
    output logic [23:0]        pixel_out,
    output logic               de_out,
    output logic               h_sync_out,
    output logic               v_sync_out,
    output logic [COORD_W-1:0] x_c,
    output logic [COORD_W-1:0] y_c,
    output logic               c_valid
);

    localparam logic [COORD_W-1:0] X_MAX  = COORD_W'(IMG_W - 1);
    localparam logic [COORD_W-1:0] Y_MAX  = COORD_W'(IMG_H - 1);
    localparam logic [COORD_W-1:0] X_INIT = COORD_W'(IMG_W / 2);
    localparam logic [COORD_W-1:0] Y_INIT = COORD_W'(IMG_H / 2);

    logic [COORD_W-1:0] x_reg, y_reg, y_pix;
    logic               de_prev_reg, vs_prev_reg;
    logic               vs_rise, de_fall, fg;
    logic [M00_W-1:0]   m00_reg, m00_eff, lat_m00_reg;
    logic [MOM_W-1:0]   m10_reg, m01_reg, lat_m01_reg;
    logic               armed_reg;
    cent_state_t        state_reg, state_next;
    logic               div_start, div_busy, div_done;
    logic [MOM_W-1:0]   div_dividend, div_divisor;
    logic [COORD_W-1:0] div_quot;
    logic [COORD_W-1:0] qx_reg, x_c_reg, y_c_reg;
    logic [23:0]        pixel_out_reg;
    logic               de_out_reg, hs_out_reg, vs_out_reg;

    assign vs_rise = v_sync_in & ~vs_prev_reg;
    assign de_fall = ~de_in & de_prev_reg;
    // A pixel coincident with the v_sync rise belongs to the new frame, i.e. row 0
    assign y_pix   = vs_rise ? '0 : y_reg;
    assign fg      = de_in & (pixel_in[7:0] != 8'd0);
    // Until the first v_sync rise after reset the frame is partial and never reported
    assign m00_eff = armed_reg ? m00_reg : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_reg       <= '0;
            y_reg       <= '0;
            de_prev_reg <= 1'b0;
            vs_prev_reg <= 1'b0;
        end else begin
            de_prev_reg <= de_in;
            vs_prev_reg <= v_sync_in;
            if (de_in)
                x_reg <= sat_inc(x_reg, X_MAX);
            else if (de_fall)
                x_reg <= '0;
            if (vs_rise)
                y_reg <= '0;
            else if (de_fall)
                y_reg <= sat_inc(y_reg, Y_MAX);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m00_reg     <= '0;
            m10_reg     <= '0;
            m01_reg     <= '0;
            lat_m00_reg <= '0;
            lat_m01_reg <= '0;
            armed_reg   <= 1'b0;
        end else if (vs_rise) begin
            lat_m00_reg <= m00_eff;
            lat_m01_reg <= m01_reg;
            armed_reg   <= 1'b1;
            m00_reg     <= fg ? M00_W'(1) : '0;
            m10_reg     <= fg ? MOM_W'(x_reg) : '0;
            m01_reg     <= fg ? MOM_W'(y_pix) : '0;
        end else if (fg) begin
            m00_reg <= m00_reg + 1'b1;
            m10_reg <= m10_reg + MOM_W'(x_reg);
            m01_reg <= m01_reg + MOM_W'(y_pix);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_reg <= ST_IDLE;
        else
            state_reg <= state_next;
    end

    // x division takes its operands straight from the accumulators on the v_sync rise
    always_comb begin
        state_next   = state_reg;
        div_start    = 1'b0;
        div_dividend = lat_m01_reg;
        div_divisor  = MOM_W'(lat_m00_reg);
        if (vs_rise) begin
            div_dividend = m10_reg;
            div_divisor  = MOM_W'(m00_eff);
            if (m00_eff != '0) begin
                state_next = ST_DIV_X;
                div_start  = 1'b1;
            end else begin
                state_next = ST_IDLE;
            end
        end else begin
            case (state_reg)
                ST_IDLE: state_next = ST_IDLE;
                ST_DIV_X: begin
                    if (div_done) begin
                        state_next = ST_DIV_Y;
                        div_start  = 1'b1;
                    end else if (!div_busy) begin
                        state_next = ST_IDLE;
                    end
                end
                ST_DIV_Y: begin
                    if (div_done)
                        state_next = ST_DONE;
                    else if (!div_busy)
                        state_next = ST_IDLE;
                end
                ST_DONE: state_next = ST_IDLE;
                default: state_next = ST_IDLE;
            endcase
        end
    end

    seq_div #(
        .QW(COORD_W)
    ) u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (div_start),
        .dividend (div_dividend),
        .divisor  (div_divisor),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (div_quot)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            qx_reg  <= '0;
            x_c_reg <= X_INIT;
            y_c_reg <= Y_INIT;
        end else begin
            if (state_reg == ST_DIV_X && state_next == ST_DIV_Y)
                qx_reg <= div_quot;
            if (state_next == ST_DONE) begin
                x_c_reg <= qx_reg;
                y_c_reg <= div_quot;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pixel_out_reg <= '0;
            de_out_reg    <= 1'b0;
            hs_out_reg    <= 1'b0;
            vs_out_reg    <= 1'b0;
        end else begin
            pixel_out_reg <= (de_in && (x_reg == x_c_reg || y_pix == y_c_reg)) ? MARK_COLOR : pixel_in;
            de_out_reg    <= de_in;
            hs_out_reg    <= h_sync_in;
            vs_out_reg    <= v_sync_in;
        end
    end

    assign pixel_out  = pixel_out_reg;
    assign de_out     = de_out_reg;
    assign h_sync_out = hs_out_reg;
    assign v_sync_out = vs_out_reg;
    assign x_c        = x_c_reg;
    assign y_c        = y_c_reg;
    assign c_valid    = (state_reg == ST_DONE);

endmodule

// File: tb/tb_centroid_overlay.sv
// Scoreboard bench: stimulus pushes expected video and centroid results into queues,
// a negedge monitor pops and compares them as the DUT presents outputs.
module tb_centroid_overlay;

    localparam int          W    = 16;
    localparam int          H    = 8;
    localparam logic [23:0] MARK = 24'hFF0000;
    localparam int          LAT  = 66;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [23:0] pixel_in = '0;
    logic        de_in = 1'b0, h_sync_in = 1'b0, v_sync_in = 1'b0;
    logic [23:0] pixel_out;
    logic        de_out, h_sync_out, v_sync_out, c_valid;
    logic [10:0] x_c, y_c;

    centroid_overlay #(
        .IMG_W      (W),
        .IMG_H      (H),
        .MARK_COLOR (MARK)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pixel_in   (pixel_in),
        .de_in      (de_in),
        .h_sync_in  (h_sync_in),
        .v_sync_in  (v_sync_in),
        .pixel_out  (pixel_out),
        .de_out     (de_out),
        .h_sync_out (h_sync_out),
        .v_sync_out (v_sync_out),
        .x_c        (x_c),
        .y_c        (y_c),
        .c_valid    (c_valid)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    typedef struct { int due; int x; int y; } res_t;
    typedef struct { int due; logic [26:0] v; } vid_t;
    res_t res_q[$];
    vid_t vid_q[$];

    // Reference model state: frame moments, current cursor, pending cursor update
    int n_fg = 0, sum_x = 0, sum_y = 0;
    bit armed = 1'b0;
    int cur_xc = W / 2, cur_yc = H / 2;
    bit pend_v = 1'b0;
    int pend_due = 0, pend_x = 0, pend_y = 0;
    bit last_vs = 1'b0;
    bit in_reset = 1'b1;

    function automatic logic [23:0] rnd_bg();
        logic [23:0] p = 24'($urandom);
        p[7:0] = 8'h00;
        return p;
    endfunction

    function automatic logic [23:0] rnd_fg();
        logic [23:0] p = 24'($urandom);
        p[7:0] = 8'($urandom_range(1, 255));
        return p;
    endfunction

    function automatic void apply_pending(input int e);
        if (pend_v && pend_due < e) begin
            cur_xc = pend_x;
            cur_yc = pend_y;
            pend_v = 1'b0;
        end
    endfunction

    task automatic step(input bit de, input bit hs, input bit vs, input logic [23:0] pix,
                        input int col, input int row);
        int e, xs, ys, last;
        vid_t ve;
        res_t r;
        logic [23:0] exp_pix;
        @(posedge clk);
        #1;
        de_in = de;
        h_sync_in = hs;
        v_sync_in = vs;
        pixel_in = pix;
        e = cyc + 1;
        apply_pending(e);
        xs = (col < W) ? col : W - 1;
        ys = (row < H) ? row : H - 1;
        exp_pix = (de && (xs == cur_xc || ys == cur_yc)) ? MARK : pix;
        ve.due = e;
        ve.v = {exp_pix, de, hs, vs};
        vid_q.push_back(ve);
        if (vs && !last_vs) begin
            last = res_q.size() - 1;
            if (last >= 0 && res_q[last].due >= e) void'(res_q.pop_back());
            if (pend_v && pend_due >= e) pend_v = 1'b0;
            if (armed && n_fg > 0) begin
                r.due = e + LAT;
                r.x = sum_x / n_fg;
                r.y = sum_y / n_fg;
                res_q.push_back(r);
                pend_v = 1'b1;
                pend_due = r.due;
                pend_x = r.x;
                pend_y = r.y;
            end
            armed = 1'b1;
            n_fg = 0;
            sum_x = 0;
            sum_y = 0;
        end
        if (de && pix[7:0] != 8'h00) begin
            n_fg++;
            sum_x += xs;
            sum_y += ys;
        end
        last_vs = vs;
    endtask

    task automatic check_hold();
        apply_pending(cyc + 1);
        @(negedge clk);
        checks++;
        if (x_c !== 11'(cur_xc) || y_c !== 11'(cur_yc)) begin
            errors++;
            $display("FAIL hold_xy cyc=%0d got=%0d,%0d exp=%0d,%0d", cyc, x_c, y_c, cur_xc, cur_yc);
        end
    endtask

    task automatic vs_porch(input int porch);
        repeat (2) step(1'b0, 1'b1, 1'b1, 24'($urandom), 0, 0);
        repeat (porch) step(1'b0, 1'b0, 1'b0, 24'($urandom), 0, 0);
    endtask

    // mode 0: all zero, 1: random, 2: single pixel (2,3), 3: 2x2 block at (4..5,4..5)
    task automatic send_frame(input int ncols, input int nrows, input int mode);
        bit f;
        logic [23:0] p;
        vs_porch(70);
        check_hold();
        for (int r = 0; r < nrows; r++) begin
            for (int c = 0; c < ncols; c++) begin
                case (mode)
                    1:       f = ($urandom_range(0, 7) == 0);
                    2:       f = (c == 2 && r == 3);
                    3:       f = (c >= 4 && c <= 5 && r >= 4 && r <= 5);
                    default: f = 1'b0;
                endcase
                p = f ? rnd_fg() : ((mode == 0) ? 24'h000000 : rnd_bg());
                step(1'b1, 1'b0, 1'b0, p, c, r);
            end
            for (int k = 0; k < 4; k++) step(1'b0, k < 2, 1'b0, 24'($urandom), 0, 0);
        end
    endtask

    task automatic do_reset(input int n);
        logic [49:0] got, exp;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        in_reset = 1'b1;
        de_in = 1'b0;
        h_sync_in = 1'b0;
        v_sync_in = 1'b0;
        pixel_in = 24'hA5C3F1;
        res_q.delete();
        vid_q.delete();
        pend_v = 1'b0;
        armed = 1'b0;
        n_fg = 0;
        sum_x = 0;
        sum_y = 0;
        cur_xc = W / 2;
        cur_yc = H / 2;
        last_vs = 1'b0;
        exp = {24'h0, 4'b0, 11'(W / 2), 11'(H / 2)};
        repeat (n) begin
            @(negedge clk);
            got = {pixel_out, de_out, h_sync_out, v_sync_out, c_valid, x_c, y_c};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL reset_outputs cyc=%0d got=%h exp=%h", cyc, got, exp);
            end
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        in_reset = 1'b0;
        pixel_in = '0;
    endtask

    vid_t        mon_v;
    res_t        mon_r;
    logic [26:0] mon_got;

    always @(negedge clk) begin
        if (!in_reset) begin
            while (vid_q.size() > 0 && vid_q[0].due < cyc) void'(vid_q.pop_front());
            if (vid_q.size() > 0 && vid_q[0].due == cyc) begin
                mon_v = vid_q.pop_front();
                mon_got = {pixel_out, de_out, h_sync_out, v_sync_out};
                checks++;
                if (mon_got !== mon_v.v) begin
                    errors++;
                    $display("FAIL video cyc=%0d got=%h exp=%h", cyc, mon_got, mon_v.v);
                end
            end
        end
        if (c_valid) begin
            checks++;
            if (res_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_c_valid cyc=%0d got x_c=%0d y_c=%0d exp no pulse", cyc, x_c, y_c);
            end else begin
                mon_r = res_q.pop_front();
                if (cyc != mon_r.due || x_c !== 11'(mon_r.x) || y_c !== 11'(mon_r.y)) begin
                    errors++;
                    $display("FAIL centroid cyc=%0d got=%0d,%0d exp=%0d,%0d at cyc %0d",
                             cyc, x_c, y_c, mon_r.x, mon_r.y, mon_r.due);
                end else begin
                    $display("centroid cyc=%0d x_c=%0d y_c=%0d ok", cyc, x_c, y_c);
                end
            end
        end
        if (res_q.size() > 0 && res_q[0].due < cyc) begin
            mon_r = res_q.pop_front();
            checks++;
            errors++;
            $display("FAIL centroid_missing cyc=%0d got no c_valid exp=%0d,%0d at cyc %0d",
                     cyc, mon_r.x, mon_r.y, mon_r.due);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog cyc=%0d got timeout exp finish", cyc);
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset(3);
        send_frame(W, H, 2);    // single pixel at (2,3)
        send_frame(W, H, 0);    // black frame: cross on column 2 / row 3
        send_frame(W, H, 3);    // previous frame empty, cursor held
        send_frame(W, H, 1);    // reports the 2x2 block
        // second v_sync rise 11 cycles after the first: first result aborted
        repeat (2) step(1'b0, 1'b1, 1'b1, 24'($urandom), 0, 0);
        repeat (5) step(1'b0, 1'b0, 1'b0, 24'($urandom), 0, 0);
        for (int c = 0; c < 3; c++) step(1'b1, 1'b0, 1'b0, rnd_fg(), c, 0);
        step(1'b0, 1'b0, 1'b0, 24'($urandom), 0, 0);
        send_frame(W, H, 1);
        send_frame(W + 4, H + 2, 1);    // oversize: coordinates saturate
        send_frame(W, H, 1);
        // reset asserted while the y division runs
        vs_porch(40);
        do_reset(3);
        send_frame(W, H, 1);    // first frame after reset is never reported
        send_frame(W, H, 1);
        vs_porch(80);
        checks++;
        if (res_q.size() != 0) begin
            errors++;
            $display("FAIL results_drained got=%0d pending exp=0", res_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/centroid_overlay.md
CENTROID_OVERLAY -- requirements
Module: centroid_overlay

Interface
REQ-001 SHALL have parameter IMG_W, default 1280, active pixels per line.
REQ-002 SHALL have parameter IMG_H, default 720, active lines per frame.
REQ-003 SHALL have parameter MARK_COLOR, default 24'hFF0000, marker RGB.
REQ-004 SHALL have port clk  input  1  pixel clock; one clock, all logic on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port pixel_in  input  24  binarised RGB; a pixel is foreground when pixel_in[7:0] != 0.
REQ-007 SHALL have ports de_in, h_sync_in, v_sync_in  input  1 each  video timing, active-high.
REQ-008 SHALL have port pixel_out  output  24  video with centroid cross overlaid.
REQ-009 SHALL have ports de_out, h_sync_out, v_sync_out  output  1 each  timing delayed to match pixel_out.
REQ-010 SHALL have ports x_c, y_c  output  11 each  latest centroid coordinates.
REQ-011 SHALL have port c_valid  output  1  one-cycle pulse when x_c/y_c update.

Function
REQ-012 SHALL count x (11 b) from 0 on each cycle with de_in=1; x clears on de_in falling edge.
REQ-013 SHALL increment y (11 b) on each de_in falling edge; y clears on v_sync_in rising edge.
REQ-014 SHALL accumulate per frame on foreground pixels: m00 += 1 (20 b), m10 += x (32 b), m01 += y (32 b).
REQ-015 SHALL, on v_sync_in rising edge, latch m00/m10/m01 into divider operands and clear the accumulators in the same cycle; a pixel in that cycle counts toward the new frame.
REQ-016 SHALL run FSM IDLE -> DIV_X -> DIV_Y -> DONE -> IDLE; leave IDLE only on a latch with latched m00 != 0.
REQ-017 SHALL compute x_c = floor(m10/m00) in DIV_X and y_c = floor(m01/m00) in DIV_Y with a 32-bit restoring divider, 32 cycles each; quotient truncated to 11 b.
REQ-018 SHALL update x_c, y_c and assert c_valid for exactly one cycle in DONE; total latency from v_sync rise to c_valid = 66 cycles.
REQ-019 SHALL, when latched m00 = 0, hold x_c/y_c and not pulse c_valid.
REQ-020 SHALL, on a v_sync_in rising edge while not IDLE, abort, relatch new moments, and restart DIV_X (or go IDLE if m00 = 0); no c_valid for the aborted frame.
REQ-021 SHALL register pixel_out and timing outputs with exactly 1-cycle latency.
REQ-022 SHALL drive pixel_out = MARK_COLOR when de_in=1 and (x == x_c or y == y_c), else pixel_in.
REQ-023 SHALL saturate x and y at IMG_W-1 / IMG_H-1 on oversize input rather than wrap.

Reset
REQ-024 SHALL, with rst_n=0, clear counters, accumulators, and divider; set FSM to IDLE.
REQ-025 SHALL, during reset, set pixel_out=0, de_out=h_sync_out=v_sync_out=0, x_c=IMG_W/2, y_c=IMG_H/2, c_valid=0.
REQ-026 SHALL, on reset assertion mid-division, discard the result; first c_valid follows the second v_sync rise after release.

Structure
REQ-027 SHALL place the coordinate width (11), accumulator widths (20/32), and FSM state encoding in shared package vp_pkg.
REQ-028 SHALL implement division in sub-module seq_div (start, dividend, divisor, busy, done, quotient), instantiated once and used for both axes.

Verification (IMG_W=16, IMG_H=8)
REQ-029 SHALL check a single foreground pixel at (2,3): c_valid 66 cycles after next v_sync rise; x_c=2, y_c=3.
REQ-030 SHALL check a 2x2 block at x=4..5, y=4..5: x_c=4, y_c=4 (floor).
REQ-031 SHALL check an all-background frame after REQ-029: no c_valid; x_c=2, y_c=3 held.
REQ-032 SHALL check a v_sync rise 10 cycles into DIV_X: no pulse for frame 1; frame-2 result reported 66 cycles after the second rise.
REQ-033 SHALL check rst_n low for 3 cycles during DIV_Y: x_c=8, y_c=4, c_valid=0; outputs 0 during reset.
REQ-034 SHALL check that with x_c=2, y_c=3, a frame of pixel_in=24'h000000 gives pixel_out=24'hFF0000 on column 2 and row 3, one cycle after input, and de_out tracks de_in by 1 cycle.
